// File: rtl/store_unit.sv
// Store unit: takes one SB/SH/SW from the MEM stage, lane-replicates the data, builds the
// byte mask and runs a word-aligned req/ack write to data memory, reporting done/error.
//
// Handshakes:
//   st_valid/st_ready : a store is taken on a rising edge where both are high
//                       (st_ready is high only in IDLE).
//   mem_req/mem_ack   : mem_req stays high with stable addr/wdata/wmask until a rising edge
//                       where mem_ack is high; mem_ack is ignored at any other time.
module store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_err,
    output logic [1:0]  st_err_code,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Counter value seen during the last allowed REQ cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q;
    logic             hs;
    logic             size_illegal;
    logic             misaligned;
    logic             timeout_hit;
    logic [31:0]      lane_wdata;
    logic [3:0]       lane_wmask;

    assign hs = st_valid && (state_q == S_IDLE);

    always_comb begin
        lane_wdata = 32'h0;
        lane_wmask = 4'b0000;
        case (st_size)
            2'b00: begin
                lane_wdata = {4{st_data[7:0]}};
                lane_wmask = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{st_data[15:0]}};
                lane_wmask = 4'b0011 << st_addr[1:0];
            end
            2'b10: begin
                lane_wdata = st_data;
                lane_wmask = 4'b1111;
            end
            default: begin
                lane_wdata = 32'h0;
                lane_wmask = 4'b0000;
            end
        endcase
    end

    assign size_illegal = (st_size == 2'b11);
    assign misaligned   = ((st_size == 2'b01) && st_addr[0]) ||
                          ((st_size == 2'b10) && (st_addr[1:0] != 2'b00));
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (size_illegal) begin
                        state_d = S_RESP;
                        code_d  = ERR_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = S_RESP;
                        code_d  = ERR_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                        code_d  = ERR_NONE;
                    end
                end
            end
            S_REQ: begin
                // An ack on the timeout edge still completes the write.
                if (mem_ack) begin
                    state_d = S_RESP;
                    code_d  = ERR_NONE;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    code_d  = ERR_TIMEOUT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                code_d  = ERR_NONE;
            end
            default: begin
                state_d = S_IDLE;
                code_d  = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Rejected stores never carry a mask, so nothing can be written for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wmask <= 4'b0000;
            cnt_q     <= '0;
        end else begin
            if (hs) begin
                mem_addr  <= {st_addr[31:2], 2'b00};
                mem_wdata <= lane_wdata;
                mem_wmask <= (size_illegal || misaligned) ? 4'b0000 : lane_wmask;
                cnt_q     <= '0;
            end else if (state_q == S_REQ) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (state_d != S_REQ) begin
                    mem_wmask <= 4'b0000;
                end
            end
        end
    end

    assign st_ready    = (state_q == S_IDLE);
    assign mem_req     = (state_q == S_REQ);
    assign st_done     = (state_q == S_RESP);
    assign st_err_code = code_q;
    assign st_err      = (code_q != ERR_NONE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: lane/mask generation, req/ack latency, error codes,
// timeout boundary and asynchronous reset in the middle of a write.
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic        st_done;
    logic        st_err;
    logic [1:0]  st_err_code;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_errors;

    store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_size     (st_size),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_ack     (mem_ack),
        .st_done     (st_done),
        .st_err      (st_err),
        .st_err_code (st_err_code),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Presents a store on a falling edge; returns on the falling edge after the handshake.
    task automatic issue(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_size  = size;
        st_addr  = addr;
        st_data  = data;
        @(negedge clk);
        st_valid = 1'b0;
        st_size  = 2'b00;
        st_addr  = 32'h0;
        st_data  = 32'h0;
    endtask

    // Legal store acked k edges after the handshake edge.
    task automatic ok_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input int k, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_mask);
        issue(size, addr, data);
        check({tag, ".req"},   32'(mem_req),   32'd1);
        check({tag, ".rdy0"},  32'(st_ready),  32'd0);
        check({tag, ".addr"},  mem_addr,       exp_addr);
        check({tag, ".wdata"}, mem_wdata,      exp_wdata);
        check({tag, ".wmask"}, 32'(mem_wmask), 32'(exp_mask));
        for (int i = 1; i < k; i++) begin
            @(negedge clk);
            check({tag, ".hold_req"},  32'(mem_req),   32'd1);
            check({tag, ".hold_mask"}, 32'(mem_wmask), 32'(exp_mask));
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check({tag, ".done"},     32'(st_done),     32'd1);
        check({tag, ".err"},      32'(st_err),      32'd0);
        check({tag, ".code"},     32'(st_err_code), 32'd0);
        check({tag, ".req_drop"}, 32'(mem_req),     32'd0);
        check({tag, ".mask_clr"}, 32'(mem_wmask),   32'd0);
        @(negedge clk);
        check({tag, ".done_1cyc"}, 32'(st_done),  32'd0);
        check({tag, ".rdy1"},      32'(st_ready), 32'd1);
    endtask

    // Store rejected without touching memory.
    task automatic bad_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                             input logic [1:0] exp_code);
        issue(size, addr, 32'hCAFEF00D);
        check({tag, ".no_req"}, 32'(mem_req),     32'd0);
        check({tag, ".mask0"},  32'(mem_wmask),   32'd0);
        check({tag, ".done"},   32'(st_done),     32'd1);
        check({tag, ".err"},    32'(st_err),      32'd1);
        check({tag, ".code"},   32'(st_err_code), 32'(exp_code));
        @(negedge clk);
        check({tag, ".done_1cyc"}, 32'(st_done),  32'd0);
        check({tag, ".rdy1"},      32'(st_ready), 32'd1);
        check({tag, ".no_req2"},   32'(mem_req),  32'd0);
    endtask

    initial begin
        int n_req;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_size  = 2'b00;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        mem_ack  = 1'b0;

        repeat (2) @(negedge clk);
        check("rst.ready", 32'(st_ready),    32'd1);
        check("rst.req",   32'(mem_req),     32'd0);
        check("rst.addr",  mem_addr,         32'h0);
        check("rst.wdata", mem_wdata,        32'h0);
        check("rst.wmask", 32'(mem_wmask),   32'd0);
        check("rst.done",  32'(st_done),     32'd0);
        check("rst.err",   32'(st_err),      32'd0);
        check("rst.code",  32'(st_err_code), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.ready", 32'(st_ready), 32'd1);

        ok_store("sb_1003", 2'b00, 32'h0000_1003, 32'hDEAD_BEEF, 2,
                 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000);
        ok_store("sh_2002", 2'b01, 32'h0000_2002, 32'h1234_ABCD, 1,
                 32'h0000_2000, 32'hABCD_ABCD, 4'b1100);
        ok_store("sb_1000", 2'b00, 32'h0000_1000, 32'h0000_0055, 1,
                 32'h0000_1000, 32'h5555_5555, 4'b0001);
        ok_store("sh_2000", 2'b01, 32'h0000_2000, 32'hFFFF_0102, 3,
                 32'h0000_2000, 32'h0102_0102, 4'b0011);
        ok_store("sw_7000", 2'b10, 32'h0000_7000, 32'h1122_3344, 1,
                 32'h0000_7000, 32'h1122_3344, 4'b1111);

        bad_store("sw_3001", 2'b10, 32'h0000_3001, 2'b01);
        bad_store("sw_3002", 2'b10, 32'h0000_3002, 2'b01);
        bad_store("sh_2001", 2'b01, 32'h0000_2001, 2'b01);
        bad_store("ill_5001", 2'b11, 32'h0000_5001, 2'b10);

        // No ack: request must stay up for exactly 16 cycles.
        issue(2'b10, 32'h0000_4000, 32'hA5A5_A5A5);
        n_req = 0;
        while (mem_req && n_req < 100) begin
            n_req++;
            @(negedge clk);
        end
        check("to.req_cycles", 32'(n_req),       32'd16);
        check("to.done",       32'(st_done),     32'd1);
        check("to.err",        32'(st_err),      32'd1);
        check("to.code",       32'(st_err_code), 32'd3);
        check("to.mask_clr",   32'(mem_wmask),   32'd0);
        @(negedge clk);
        check("to.rdy1", 32'(st_ready), 32'd1);

        // Ack arriving on the timeout edge wins.
        ok_store("to_edge_ack", 2'b10, 32'h0000_4004, 32'h0BAD_CAFE, 16,
                 32'h0000_4004, 32'h0BAD_CAFE, 4'b1111);

        // Asynchronous reset in the middle of REQ.
        issue(2'b10, 32'h0000_6000, 32'h6666_6666);
        check("arst.pre_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.req",   32'(mem_req),   32'd0);
        check("arst.wmask", 32'(mem_wmask), 32'd0);
        check("arst.ready", 32'(st_ready),  32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("arst.ack_ignored_req",  32'(mem_req),  32'd0);
            check("arst.ack_ignored_done", 32'(st_done),  32'd0);
            check("arst.ready_after",      32'(st_ready), 32'd1);
        end
        mem_ack = 1'b0;

        ok_store("post_rst_sw", 2'b10, 32'h0000_8008, 32'hFEED_0001, 2,
                 32'h0000_8008, 32'hFEED_0001, 4'b1111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
